// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer
//   Walks the active elements of a vector operation through a single external
//   lane ALU, one element per clock, and assembles the destination register.
//   FSM: IDLE -> RUN (vl cycles) -> DONE (one cycle) -> IDLE; IDLE -> DONE when vl = 0.
//
// Build option:
//   VECTOR_SEQ_TAIL_AGNOSTIC_EN  defined   : tail slots / tail mask bits are written all-ones
//                                undefined : tail slots / tail mask bits keep vd_old
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    operation request, accepted only in IDLE
//   opcode, vsew, vl, vm     operation controls (vl clamped to VECTOR_SIZE)
//   is_mask_operation        result is one bit per element
//   vs1_data, vs2_data       packed source operands, element i at [64i+63:64i]
//   vd_old                   previous destination contents
//   mask_data                v0 mask, bit i for element i
//   imm, rs                  immediate and scalar operands
//   alu_result               combinational result from the lane ALU
//   alu_*                    current element operands/controls (zero outside RUN)
//   busy                     high in RUN and DONE
//   done                     one-cycle completion pulse
//   vd_data                  assembled destination, held until the next accepted start
module vector_alu_sequencer #(
  parameter int LONGEST_LEN      = 64,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int LEN              = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [5:0]                        opcode,
  input  logic [2:0]                        vsew,
  input  logic [ENTRY_INDEX_SIZE:0]         vl,
  input  logic                              vm,
  input  logic                              is_mask_operation,
  input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs1_data,
  input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vs2_data,
  input  logic [VECTOR_SIZE*LONGEST_LEN-1:0] vd_old,
  input  logic [VECTOR_SIZE-1:0]            mask_data,
  input  logic [LEN-1:0]                    imm,
  input  logic [LEN-1:0]                    rs,
  input  logic [LONGEST_LEN-1:0]            alu_result,
  output logic [LONGEST_LEN-1:0]            alu_vs1,
  output logic [LONGEST_LEN-1:0]            alu_vs2,
  output logic                              alu_mask,
  output logic                              alu_vm,
  output logic                              alu_is_mask_operation,
  output logic [5:0]                        alu_opcode,
  output logic [2:0]                        alu_vsew,
  output logic [LEN-1:0]                    alu_imm,
  output logic [LEN-1:0]                    alu_rs,
  output logic                              busy,
  output logic                              done,
  output logic [VECTOR_SIZE*LONGEST_LEN-1:0] vd_data
);

  localparam int VW = VECTOR_SIZE * LONGEST_LEN;

  // Carry/borrow-in ops consume v0 as data, so they always write their result.
  localparam logic [5:0] VECTOR_ADC = 6'b010000;
  localparam logic [5:0] VECTOR_SBC = 6'b010010;

  localparam logic [ENTRY_INDEX_SIZE:0]   VL_ONE  = (ENTRY_INDEX_SIZE+1)'(1);
  localparam logic [ENTRY_INDEX_SIZE:0]   VL_MAX  = (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE);
  localparam logic [ENTRY_INDEX_SIZE-1:0] IDX_ONE = ENTRY_INDEX_SIZE'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [5:0]                  opcode_q;
  logic [2:0]                  vsew_q;
  logic [ENTRY_INDEX_SIZE:0]   vl_q;
  logic                        vm_q;
  logic                        mask_op_q;
  logic [VW-1:0]               vs1_q;
  logic [VW-1:0]               vs2_q;
  logic [VECTOR_SIZE-1:0]      mask_q;
  logic [LEN-1:0]              imm_q;
  logic [LEN-1:0]              rs_q;
  logic [VW-1:0]               vd_q;
  logic [ENTRY_INDEX_SIZE-1:0] idx_q;

  logic [ENTRY_INDEX_SIZE:0]   vl_clamped;
  logic                        accept;
  logic                        last_elem;
  logic                        elem_active;
  logic [LONGEST_LEN-1:0]      cur_vs1;
  logic [LONGEST_LEN-1:0]      cur_vs2;
  logic [VW-1:0]               vd_init;
  logic [VW-1:0]               vd_next;

  assign vl_clamped = (vl > VL_MAX) ? VL_MAX : vl;
  assign accept     = (state_q == IDLE) && start;
  assign last_elem  = ({1'b0, idx_q} == (vl_q - VL_ONE));
  assign elem_active = vm_q || mask_q[idx_q] ||
                       (opcode_q == VECTOR_ADC) || (opcode_q == VECTOR_SBC);

  // Destination image loaded at accept: old contents with the tail policy
  // already applied, so RUN only has to overwrite active elements.
  always_comb begin
    vd_init = vd_old;
`ifdef VECTOR_SEQ_TAIL_AGNOSTIC_EN
    for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
      if ((ENTRY_INDEX_SIZE+1)'(i) >= vl_clamped) begin
        if (is_mask_operation)
          vd_init[i] = 1'b1;
        else
          vd_init[i*LONGEST_LEN +: LONGEST_LEN] = '1;
      end
    end
`endif
  end

  always_comb begin
    cur_vs1 = '0;
    cur_vs2 = '0;
    vd_next = vd_q;
    for (int unsigned i = 0; i < VECTOR_SIZE; i++) begin
      if (idx_q == ENTRY_INDEX_SIZE'(i)) begin
        cur_vs1 = vs1_q[i*LONGEST_LEN +: LONGEST_LEN];
        cur_vs2 = vs2_q[i*LONGEST_LEN +: LONGEST_LEN];
        if (elem_active) begin
          if (mask_op_q)
            vd_next[i] = alu_result[0];
          else
            vd_next[i*LONGEST_LEN +: LONGEST_LEN] = alu_result;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vl_clamped == '0) ? DONE : RUN;
      RUN:     if (last_elem) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy                  = (state_q != IDLE);
    done                  = (state_q == DONE);
    alu_vs1               = '0;
    alu_vs2               = '0;
    alu_mask              = 1'b0;
    alu_vm                = 1'b0;
    alu_is_mask_operation = 1'b0;
    alu_opcode            = '0;
    alu_vsew              = '0;
    alu_imm               = '0;
    alu_rs                = '0;
    if (state_q == RUN) begin
      alu_vs1               = cur_vs1;
      alu_vs2               = cur_vs2;
      alu_mask              = mask_q[idx_q];
      alu_vm                = vm_q;
      alu_is_mask_operation = mask_op_q;
      alu_opcode            = opcode_q;
      alu_vsew              = vsew_q;
      alu_imm               = imm_q;
      alu_rs                = rs_q;
    end
  end

  assign vd_data = vd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q  <= '0;
      vsew_q    <= '0;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      mask_op_q <= 1'b0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      mask_q    <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      vd_q      <= '0;
      idx_q     <= '0;
    end else if (accept) begin
      opcode_q  <= opcode;
      vsew_q    <= vsew;
      vl_q      <= vl_clamped;
      vm_q      <= vm;
      mask_op_q <= is_mask_operation;
      vs1_q     <= vs1_data;
      vs2_q     <= vs2_data;
      mask_q    <= mask_data;
      imm_q     <= imm;
      rs_q      <= rs;
      vd_q      <= vd_init;
      idx_q     <= '0;
    end else if (state_q == RUN) begin
      idx_q <= idx_q + IDX_ONE;
      vd_q  <= vd_next;
    end
  end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
module tb_vector_alu_sequencer;

  localparam int LL = 64;
  localparam int VS = 8;
  localparam int VW = VS * LL;
  localparam int BW = 204;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ADC  = 6'b010000;
  localparam logic [5:0] OP_MADC = 6'b010001;
  localparam logic [5:0] OP_SBC  = 6'b010010;

  typedef struct {
    logic [5:0]    op;
    logic [2:0]    sew;
    logic [3:0]    vl;
    logic          vm;
    logic          mop;
    logic [VW-1:0] vs1;
    logic [VW-1:0] vs2;
    logic [VW-1:0] vdo;
    logic [7:0]    mask;
    logic [31:0]   imm;
    logic [31:0]   rs;
  } txn_t;

  typedef struct {
    logic [VW-1:0] vd;
    int unsigned   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [5:0] opcode = '0;
  logic [2:0] vsew = '0;
  logic [3:0] vl = '0;
  logic vm = 1'b0;
  logic is_mask_operation = 1'b0;
  logic [VW-1:0] vs1_data = '0, vs2_data = '0, vd_old = '0;
  logic [7:0] mask_data = '0;
  logic [31:0] imm = '0, rs = '0;
  logic [LL-1:0] alu_result;
  logic [LL-1:0] alu_vs1, alu_vs2;
  logic alu_mask, alu_vm, alu_is_mask_operation;
  logic [5:0] alu_opcode;
  logic [2:0] alu_vsew;
  logic [31:0] alu_imm, alu_rs;
  logic busy, done;
  logic [VW-1:0] vd_data;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  exp_t exp_q[$];
  logic [BW-1:0] elem_q[$];
  logic [VW-1:0] last_vd = '0;

  vector_alu_sequencer #(
    .LONGEST_LEN(64), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3), .LEN(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .vsew(vsew), .vl(vl),
    .vm(vm), .is_mask_operation(is_mask_operation), .vs1_data(vs1_data),
    .vs2_data(vs2_data), .vd_old(vd_old), .mask_data(mask_data), .imm(imm), .rs(rs),
    .alu_result(alu_result), .alu_vs1(alu_vs1), .alu_vs2(alu_vs2), .alu_mask(alu_mask),
    .alu_vm(alu_vm), .alu_is_mask_operation(alu_is_mask_operation),
    .alu_opcode(alu_opcode), .alu_vsew(alu_vsew), .alu_imm(alu_imm), .alu_rs(alu_rs),
    .busy(busy), .done(done), .vd_data(vd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Lane ALU stand-in: element width from vsew, carry/borrow-in from v0 bit.
  function automatic logic [LL-1:0] alu_fn(input logic [5:0] op, input logic [2:0] sew,
                                           input logic [LL-1:0] a_in, input logic [LL-1:0] b_in,
                                           input logic m, input logic vmi);
    int unsigned w;
    logic [LL-1:0] msk, a, b, r;
    logic [LL:0] s;
    w = (sew > 3) ? 64 : (8 << sew);
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a = a_in & msk;
    b = b_in & msk;
    case (op)
      OP_ADD:  r = (b + a) & msk;
      OP_SUB:  r = (b - a) & msk;
      OP_ADC:  r = (b + a + {63'd0, m}) & msk;
      OP_SBC:  r = (b - a - {63'd0, m}) & msk;
      OP_MADC: begin
        s = {1'b0, b} + {1'b0, a} + {64'd0, (vmi ? 1'b0 : m)};
        r = {63'd0, s[w]};
      end
      default: r = b ^ a;
    endcase
    return r;
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_vsew, alu_vs1, alu_vs2, alu_mask, alu_vm);

  function automatic int unsigned eff_vl(input txn_t t);
    return (t.vl > 8) ? 8 : int'(t.vl);
  endfunction

  // Destination computed straight from the element rules.
  function automatic logic [VW-1:0] ref_vd(input txn_t t);
    logic [VW-1:0] r;
    logic [LL-1:0] res;
    int unsigned n;
    r = t.vdo;
    n = eff_vl(t);
    for (int i = 0; i < VS; i++) begin
      if (i >= n) begin
`ifdef VECTOR_SEQ_TAIL_AGNOSTIC_EN
        if (t.mop) r[i] = 1'b1;
        else r[i*LL +: LL] = '1;
`endif
      end else if (t.vm || t.mask[i] || t.op == OP_ADC || t.op == OP_SBC) begin
        res = alu_fn(t.op, t.sew, t.vs1[i*LL +: LL], t.vs2[i*LL +: LL], t.mask[i], t.vm);
        if (t.mop) r[i] = res[0];
        else r[i*LL +: LL] = res;
      end
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_expect(input txn_t t, input int unsigned s);
    exp_t e;
    e.vd = ref_vd(t);
    e.cyc = s + eff_vl(t) + 1;
    exp_q.push_back(e);
    for (int i = 0; i < eff_vl(t); i++)
      elem_q.push_back({t.vs1[i*LL +: LL], t.vs2[i*LL +: LL], t.mask[i], t.vm, t.mop,
                        t.op, t.sew, t.imm, t.rs});
  endtask

  task automatic drive(input txn_t t);
    opcode = t.op; vsew = t.sew; vl = t.vl; vm = t.vm; is_mask_operation = t.mop;
    vs1_data = t.vs1; vs2_data = t.vs2; vd_old = t.vdo; mask_data = t.mask;
    imm = t.imm; rs = t.rs;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", VW'(busy), '0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input txn_t t);
    wait_idle();
    drive(t);
    start = 1'b1;
    push_expect(t, cyc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (!done) check("done_timeout", VW'(done), VW'(1));
  endtask

  function automatic txn_t blank();
    txn_t t;
    t.op = OP_ADD; t.sew = 3'd2; t.vl = 4'd8; t.vm = 1'b1; t.mop = 1'b0;
    t.vs1 = '0; t.vs2 = '0; t.vdo = '0; t.mask = '0; t.imm = '0; t.rs = '0;
    return t;
  endfunction

  function automatic txn_t gen_rand();
    txn_t t;
    logic [5:0] ops [5];
    ops = '{OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_MADC};
    t.op = ops[$urandom_range(0, 4)];
    t.sew = 3'($urandom_range(0, 3));
    t.vl = 4'($urandom_range(0, 15));
    t.vm = 1'($urandom);
    t.mop = (t.op == OP_MADC) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
    for (int i = 0; i < VS * 2; i++) begin
      t.vs1[i*32 +: 32] = $urandom;
      t.vs2[i*32 +: 32] = $urandom;
      t.vdo[i*32 +: 32] = $urandom;
    end
    t.mask = 8'($urandom);
    t.imm = $urandom;
    t.rs = $urandom;
    return t;
  endfunction

  // Monitor: pops element and completion expectations as the DUT presents them.
  initial begin
    exp_t e;
    logic [BW-1:0] eb;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy && !done) begin
          if (elem_q.size() == 0) check("extra_elem", VW'(1), '0);
          else begin
            eb = elem_q.pop_front();
            check("alu_elem", VW'({alu_vs1, alu_vs2, alu_mask, alu_vm, alu_is_mask_operation,
                                   alu_opcode, alu_vsew, alu_imm, alu_rs}), VW'(eb));
          end
        end else begin
          check("alu_idle", VW'({alu_vs1, alu_vs2, alu_mask, alu_vm, alu_is_mask_operation,
                                 alu_opcode, alu_vsew, alu_imm, alu_rs}), '0);
        end
        if (done) begin
          if (exp_q.size() == 0) check("spurious_done", VW'(1), '0);
          else begin
            e = exp_q.pop_front();
            check("vd", vd_data, e.vd);
            check("latency", VW'(cyc), VW'(e.cyc));
            check("busy_in_done", VW'(busy), VW'(1));
            last_vd = e.vd;
          end
        end
        if (!busy) check("vd_hold", vd_data, last_vd);
      end
    end
  end

  initial begin
    txn_t t;
    logic [VW-1:0] x;
    int unsigned s;
    #1;
    check("rst_busy", VW'(busy), '0);
    check("rst_done", VW'(done), '0);
    check("rst_vd", vd_data, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Add, full vector: slot i = 10 + i
    t = blank();
    for (int i = 0; i < VS; i++) begin
      t.vs1[i*LL +: LL] = 64'(i);
      t.vs2[i*LL +: LL] = 64'd10;
    end
    issue(t);
    wait_done();
    for (int i = 0; i < VS; i++) check("add_slot", VW'(vd_data[i*LL +: LL]), VW'(10 + i));

    // Sub, vl=4, masked
    t = blank();
    t.op = OP_SUB; t.vl = 4'd4; t.vm = 1'b0; t.mask = 8'b0000_0101;
    for (int i = 0; i < VS; i++) begin
      t.vs1[i*LL +: LL] = 64'h10;
      t.vs2[i*LL +: LL] = 64'h50 + 64'(i);
      t.vdo[i*LL +: LL] = 64'hAA;
    end
    issue(t);
    wait_done();
    check("sub_slot0", VW'(vd_data[0 +: LL]), VW'(64'h40));
    check("sub_slot1", VW'(vd_data[LL +: LL]), VW'(64'hAA));
    check("sub_slot2", VW'(vd_data[2*LL +: LL]), VW'(64'h42));
    check("sub_slot3", VW'(vd_data[3*LL +: LL]), VW'(64'hAA));
`ifdef VECTOR_SEQ_TAIL_AGNOSTIC_EN
    x = '1;
`else
    x = {VS{64'hAA}};
`endif
    check("sub_tail", VW'(vd_data[VW-1:4*LL]), VW'(x[VW-1:4*LL]));

    // vl = 0
    t = blank();
    t.vl = 4'd0;
    for (int i = 0; i < VS * 2; i++) t.vdo[i*32 +: 32] = $urandom;
    issue(t);
    wait_done();
`ifdef VECTOR_SEQ_TAIL_AGNOSTIC_EN
    check("vl0_vd", vd_data, '1);
`else
    check("vl0_vd", vd_data, t.vdo);
`endif

    // Mask-producing carry-out, byte elements
    t = blank();
    t.op = OP_MADC; t.mop = 1'b1; t.sew = 3'd0;
    for (int i = 0; i < VS; i++) begin
      t.vs1[i*LL +: LL] = (i % 2 == 0) ? 64'h80 : 64'h01;
      t.vs2[i*LL +: LL] = (i % 2 == 0) ? 64'h80 : 64'h01;
    end
    issue(t);
    wait_done();
    check("madc_bits", VW'(vd_data[7:0]), VW'(8'b0101_0101));

    // vl above VECTOR_SIZE clamps to 8
    t = gen_rand();
    t.vl = 4'd13;
    issue(t);
    s = cyc - 1;
    wait_done();
    check("clamp_latency", VW'(cyc), VW'(s + 9));

    // Reset in the middle of RUN, at idx 3
    t = gen_rand();
    t.vl = 4'd8;
    issue(t);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    elem_q.delete();
    last_vd = '0;
    #1;
    check("midrst_busy", VW'(busy), '0);
    check("midrst_done", VW'(done), '0);
    check("midrst_vd", vd_data, '0);
    @(posedge clk); #1;
    check("midrst_hold_done", VW'(done), '0);
    rst = 1'b0;
    t = gen_rand();
    t.vl = 4'd5;
    issue(t);
    wait_done();

    // Start held high across two operations
    t = gen_rand();
    t.vl = 4'd3;
    wait_idle();
    drive(t);
    start = 1'b1;
    s = cyc;
    push_expect(t, s);
    push_expect(t, s + 3 + 2);
    repeat (3 + 3) @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      issue(gen_rand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    check("exp_drain", VW'(exp_q.size()), '0);
    check("elem_drain", VW'(elem_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_alu_sequencer.md
VECTOR_ALU_SEQUENCER -- requirements
Module: vector_alu_sequencer

Interface
REQ-001 SHALL have parameters:
- LONGEST_LEN, 64, element slot width
- VECTOR_SIZE, 8, elements per vector register
- ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE)
- LEN, 32, scalar/immediate width
REQ-002 SHALL have the following ports, clock and reset first:
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  operation request
- opcode  input  6  vector ALU opcode
- vsew  input  3  element width code
- vl  input  ENTRY_INDEX_SIZE+1  active element count
- vm  input  1  1 = unmasked
- is_mask_operation  input  1  result is 1 bit per element
- vs1_data, vs2_data, vd_old  input  VECTOR_SIZE*LONGEST_LEN  packed operands and old destination; element i at bits [64i+63:64i]
- mask_data  input  VECTOR_SIZE  v0 mask, bit i for element i
- imm, rs  input  LEN  immediate and scalar operand
- alu_result  input  LONGEST_LEN  combinational result from the lane ALU
- alu_vs1, alu_vs2  output  LONGEST_LEN  current element operands
- alu_mask, alu_vm, alu_is_mask_operation  output  1  current element controls
- alu_opcode  output  6  opcode to the ALU
- alu_vsew  output  3  drives the ALU's PREV_VSEW and CUR_VSEW
- alu_imm, alu_rs  output  LEN  scalar operands to the ALU
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- vd_data  output  VECTOR_SIZE*LONGEST_LEN  assembled destination

Function
REQ-003 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-004 SHALL accept start only in IDLE and ignore start in RUN or DONE.
REQ-005 On acceptance, SHALL latch every operand and control input.
REQ-006 SHALL clamp a latched vl greater than VECTOR_SIZE to VECTOR_SIZE.
REQ-007 SHALL go IDLE -> DONE directly when the latched vl = 0; otherwise IDLE -> RUN with element counter = 0.
REQ-008 In RUN, SHALL present element idx on the alu_* outputs and capture alu_result at that cycle's clock edge; alu_mask = mask_data[idx].
REQ-009 SHALL increment idx each RUN cycle and go to DONE after the element with idx = vl-1 is captured; RUN lasts exactly vl cycles.
REQ-010 SHALL assert busy in RUN and DONE.
REQ-011 SHALL assert done only in DONE, for exactly one cycle, with vd_data valid that cycle; vd_data SHALL hold until the next accepted start.
REQ-012 Latency from start accept to done SHALL be vl+1 cycles, minimum 1 cycle.
REQ-013 Masked-off element (vm=0 and mask bit 0): SHALL keep the vd_old slot, except for VECTOR_ADC and VECTOR_SBC, which SHALL always write alu_result.
REQ-014 When is_mask_operation=1, SHALL write alu_result[0] to vd_data bit i; the remaining bits of bits [VECTOR_SIZE-1:0] SHALL follow REQ-016, and bits [VECTOR_SIZE*LONGEST_LEN-1:VECTOR_SIZE] SHALL come from vd_old.
REQ-015 When is_mask_operation=0, SHALL write the full 64-bit alu_result to slot i.
REQ-016 Tail elements (i >= vl) SHALL follow Configuration.
REQ-017 Outside RUN, SHALL drive all alu_* outputs to 0.

Reset
REQ-018 Asserting rst at any time, including mid-RUN, SHALL immediately force IDLE with busy=0, done=0, vd_data=0, counter=0 and all latched state cleared; no done pulse SHALL follow.
REQ-019 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-020 The feature macro SHALL be VECTOR_SEQ_TAIL_AGNOSTIC_EN.
- Defined: tail slots (or tail mask bits) SHALL be written all-ones.
- Undefined: tail slots (or tail mask bits) SHALL keep vd_old.

Verification
REQ-021 VECTOR_ADD, vsew=FOUR_BYTE, vl=8, vm=1, vs1 slot i = i, vs2 slot i = 10 -> done exactly 9 cycles after start, vd slot i = 10+i.
REQ-022 VECTOR_SUB, vl=4, vm=0, mask_data=8'b0000_0101, vd_old slots = 0xAA -> slots 0 and 2 hold the ALU result, slots 1 and 3 = 0xAA, slots 4-7 tail per macro (0xAA undefined / all-ones defined).
REQ-023 vl=0 -> done 1 cycle after start, no alu activity, vd = vd_old (or all-ones when the macro is defined).
REQ-024 VECTOR_MADC with is_mask_operation=1, vl=8, ONE_BYTE, vs1=vs2=0x80 in even slots and 0x01 in odd slots -> vd bits[7:0]=8'b0101_0101.
REQ-025 Assert rst at RUN idx=3 -> busy=0, vd=0 immediately, no done; a new start 1 cycle after release completes normally.
REQ-026 start asserted continuously through an operation -> exactly one operation per IDLE visit, with no start accepted while busy=1.
